elevator_ctrl: RTL

ELEVATOR_CTRL -- requirements
Module: elevator_ctrl

---
 rtl/elev_pkg.sv | 84 ++++++++
 rtl/tick_gen.sv | 41 ++++
 rtl/elevator_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/elev_pkg.sv
// elev_pkg: shared FSM encodings, status codes, direction codes and the
// SCAN dispatch helper used by elevator_ctrl.
package elev_pkg;

    localparam int NUM_FLOORS = 4;
    localparam int FLOOR_W    = 2;
    localparam int CNT_W      = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MOVE = 2'd1,
        ST_DOOR = 2'd2
    } state_e;

    localparam logic [1:0] STA_IDLE = 2'd0;
    localparam logic [1:0] STA_UP   = 2'd1;
    localparam logic [1:0] STA_DOWN = 2'd2;
    localparam logic [1:0] STA_DOOR = 2'd3;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Outcome of a scheduling decision taken at a floor.
    typedef struct packed {
        state_e state;
        logic   dir;
        logic   serve;
    } dispatch_t;

    function automatic logic calls_above(input logic [NUM_FLOORS-1:0] calls,
                                         input logic [FLOOR_W-1:0]    fl);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if ((i > int'(fl)) && calls[i]) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic logic calls_below(input logic [NUM_FLOORS-1:0] calls,
                                         input logic [FLOOR_W-1:0]    fl);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if ((i < int'(fl)) && calls[i]) hit = 1'b1;
        end
        return hit;
    endfunction

    // Serve the current floor first; otherwise keep travelling the same way
    // while calls remain ahead, reverse only when calls lie behind, else rest.
    // A move is only ever chosen toward a floor that holds a call, so the
    // cab can never be sent beyond the end floors.
    function automatic dispatch_t dispatch(input logic [NUM_FLOORS-1:0] calls,
                                           input logic [FLOOR_W-1:0]    fl,
                                           input logic                  dir);
        dispatch_t d;
        logic      up_hit;
        logic      dn_hit;
        up_hit  = calls_above(calls, fl);
        dn_hit  = calls_below(calls, fl);
        d.state = ST_IDLE;
        d.dir   = dir;
        d.serve = 1'b0;
        if (calls[fl]) begin
            d.state = ST_DOOR;
            d.serve = 1'b1;
        end else if ((dir == DIR_UP) && up_hit) begin
            d.state = ST_MOVE;
            d.dir   = DIR_UP;
        end else if ((dir == DIR_DOWN) && dn_hit) begin
            d.state = ST_MOVE;
            d.dir   = DIR_DOWN;
        end else if (up_hit) begin
            d.state = ST_MOVE;
            d.dir   = DIR_UP;
        end else if (dn_hit) begin
            d.state = ST_MOVE;
            d.dir   = DIR_DOWN;
        end
        return d;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// tick_gen: free-running prescaler producing a one-cycle tick every
// TICK_CYCLES clocks. restart_i zeroes the count so a new phase gets a full
// first second; hold_i freezes the count and suppresses the tick.
module tick_gen
    import elev_pkg::*;
#(
    parameter int TICK_CYCLES = 50000000
) (
    input  logic clkin,
    input  logic rst,
    input  logic restart_i,
    input  logic hold_i,
    output logic tick_o
);

    localparam int            CW   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign tick_o = (count_q == LAST) && !hold_i;

    // Next count: restart wins, hold freezes, otherwise wrap at LAST.
    always_comb begin
        count_d = count_q;
        if (restart_i) begin
            count_d = '0;
        end else if (!hold_i) begin
            if (count_q == LAST) count_d = '0;
            else                 count_d = count_q + CW'(1);
        end
    end

    // Prescaler register.
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

endmodule

// File: rtl/elevator_ctrl.sv
// elevator_ctrl: four-floor elevator controller with SCAN scheduling.
// Call buttons are synchronised and edge-detected into a pending-call
// register; an IDLE/MOVE/DOOR FSM times each phase in seconds from tick_gen.
// Optional feature: define ELEV_ESTOP_EN to add an emergency-stop input that
// freezes the FSM, the phase counter and the prescaler while asserted.
module elevator_ctrl
    import elev_pkg::*;
#(
    parameter int TICK_CYCLES = 50000000,
    parameter int MOVE_S      = 3,
    parameter int DOOR_S      = 5
) (
    input  logic                  clkin,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] req,
    output logic [FLOOR_W-1:0]    floor,
    output logic [1:0]            sta,
    output logic [CNT_W-1:0]      cnt,
    output logic [NUM_FLOORS-1:0] pend
`ifdef ELEV_ESTOP_EN
    ,
    input  logic                  estop
`endif
);

    localparam logic [CNT_W-1:0]      MOVE_CNT  = CNT_W'(MOVE_S);
    localparam logic [CNT_W-1:0]      DOOR_CNT  = CNT_W'(DOOR_S);
    localparam logic [FLOOR_W-1:0]    TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);
    localparam logic [NUM_FLOORS-1:0] ONE_HOT0  = NUM_FLOORS'(1);

    logic [NUM_FLOORS-1:0] req_s1_q, req_s2_q, req_s3_q;
    logic [NUM_FLOORS-1:0] call_edge;
    logic [NUM_FLOORS-1:0] call_accept;
    logic [NUM_FLOORS-1:0] serve_mask;
    logic [NUM_FLOORS-1:0] pend_q, pend_d;
    state_e                state_q, state_d;
    logic                  dir_q, dir_d;
    logic [FLOOR_W-1:0]    floor_q, floor_d;
    logic [FLOOR_W-1:0]    arrive_floor;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [1:0]            sta_q, sta_d;
    logic                  tick;
    logic                  restart;
    logic                  frozen;
    logic                  door_call;
    logic                  apply;
    dispatch_t             disp_here;
    dispatch_t             disp_arrive;
    dispatch_t             disp_sel;

    // Two-flop synchroniser plus one delay stage for rising-edge detection.
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            req_s1_q <= '0;
            req_s2_q <= '0;
            req_s3_q <= '0;
        end else begin
            req_s1_q <= req;
            req_s2_q <= req_s1_q;
            req_s3_q <= req_s2_q;
        end
    end

    // A held button produces one edge only. A call for the floor whose doors
    // are open is not latched; it extends the door time instead.
    for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_call
        assign call_edge[gi]   = req_s2_q[gi] & ~req_s3_q[gi];
        assign call_accept[gi] = call_edge[gi] &
                                 ~((state_q == ST_DOOR) && (floor_q == FLOOR_W'(gi)));
    end

    assign door_call = (state_q == ST_DOOR) && call_edge[floor_q];

`ifdef ELEV_ESTOP_EN
    logic estop_s1_q, estop_s2_q;

    // Emergency-stop synchroniser; its output freezes the controller.
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            estop_s1_q <= 1'b0;
            estop_s2_q <= 1'b0;
        end else begin
            estop_s1_q <= estop;
            estop_s2_q <= estop_s1_q;
        end
    end

    assign frozen = estop_s2_q;
`else
    assign frozen = 1'b0;
`endif

    tick_gen #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_tick_gen (
        .clkin    (clkin),
        .rst      (rst),
        .restart_i(restart),
        .hold_i   (frozen),
        .tick_o   (tick)
    );

    // Floor reached at the end of a move, clamped to the building.
    always_comb begin
        arrive_floor = floor_q;
        if ((dir_q == DIR_UP) && (floor_q != TOP_FLOOR))
            arrive_floor = floor_q + FLOOR_W'(1);
        else if ((dir_q == DIR_DOWN) && (floor_q != '0))
            arrive_floor = floor_q - FLOOR_W'(1);
    end

    assign disp_here   = dispatch(pend_q, floor_q, dir_q);
    assign disp_arrive = dispatch(pend_q, arrive_floor, dir_q);

    // FSM next state: count down the phase, then dispatch from the floor.
    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        floor_d    = floor_q;
        cnt_d      = cnt_q;
        restart    = 1'b0;
        serve_mask = '0;
        apply      = 1'b0;
        disp_sel   = disp_here;
        if (!frozen) begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    apply = 1'b1;
                end
                ST_MOVE: begin
                    if (tick) begin
                        if (cnt_q > CNT_W'(1)) begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end else begin
                            floor_d  = arrive_floor;
                            disp_sel = disp_arrive;
                            apply    = 1'b1;
                        end
                    end
                end
                ST_DOOR: begin
                    if (door_call) begin
                        cnt_d   = DOOR_CNT;
                        restart = 1'b1;
                    end else if (tick) begin
                        if (cnt_q > CNT_W'(1)) cnt_d = cnt_q - CNT_W'(1);
                        else                   apply = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
            if (apply) begin
                state_d = disp_sel.state;
                dir_d   = disp_sel.dir;
                case (disp_sel.state)
                    ST_MOVE: cnt_d = MOVE_CNT;
                    ST_DOOR: cnt_d = DOOR_CNT;
                    default: cnt_d = '0;
                endcase
                restart = (disp_sel.state != ST_IDLE);
                if (disp_sel.serve) serve_mask = ONE_HOT0 << floor_d;
            end
        end
    end

    // A new edge and a clear of the same bit together leave it served.
    assign pend_d = (pend_q | call_accept) & ~serve_mask;

    // Status code follows the next state so it is registered with it.
    always_comb begin
        case (state_d)
            ST_MOVE: sta_d = (dir_d == DIR_UP) ? STA_UP : STA_DOWN;
            ST_DOOR: sta_d = STA_DOOR;
            default: sta_d = STA_IDLE;
        endcase
    end

    // FSM, position, phase counter, status and pending-call registers.
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dir_q   <= DIR_UP;
            floor_q <= '0;
            cnt_q   <= '0;
            sta_q   <= STA_IDLE;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            floor_q <= floor_d;
            cnt_q   <= cnt_d;
            sta_q   <= sta_d;
            pend_q  <= pend_d;
        end
    end

    assign floor = floor_q;
    assign sta   = sta_q;
    assign cnt   = cnt_q;
    assign pend  = pend_q;

endmodule
